cpu: RTL and testbench
======================

CPU -- requirements
Module: cpu

Interface
REQ-001 Parameter IMEM_WORDS, default 256, sets instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_BYTES, default 32, sets data memory depth in bytes.
REQ-003 Port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 Port start_i  input  1  run enable; when 0 the PC holds its value.
REQ-006 The block SHALL expose these hierarchical state names for bench access:
- Instruction_Memory.memory[0..255]: 32-bit words.
- Data_Memory.memory[0..31]: 8-bit bytes.
- Registers.register[0..31]: 32-bit.
- PC.pc_o: 32-bit.
- HD_Unit.data_o: stall request.
- Control.IsJump_o and Control.Branch_o.
- flush: 1-bit.

Function
REQ-007 The cpu SHALL be a 5-stage in-order pipeline (IF, ID, EX, MEM, WB) with IF/ID, ID/EX, EX/MEM and MEM/WB registers.
REQ-008 IF SHALL fetch Instruction_Memory.memory[pc>>2]; next PC = PC+4 unless stalled, branch-taken or jump.
REQ-009 Supported instructions:
- R-type (opcode 000000) funct: add 100000, sub 100010, and 100100, or 100101, mul 011000 (low 32 bits of product).
- addi 001000.
- lw 100011, sw 101011: word access, address = rs + signext(imm).
- beq 000100.
- j 000010.
- Any other encoding, including all-zero, executes as a NOP with no register or memory write.
REQ-010 Arithmetic SHALL be 32-bit two's complement, wrap-around with no overflow trap; immediates sign-extended from 16 bits.
REQ-011 Data memory words SHALL be little-endian: byte addr+0 is bits [7:0], addr+3 is bits [31:24]; sw writes 4 bytes in MEM; lw reads combinationally in MEM.
REQ-012 Register 0 SHALL read 0 and ignore writes; WB SHALL write rd (R-type) or rt (addi, lw) on the rising edge.
REQ-013 Register file SHALL bypass: a read in ID of the register being written in WB the same cycle returns the new value.
REQ-014 Forwarding unit in EX SHALL select each ALU operand from EX/MEM result (priority) or MEM/WB result when the source register matches a writing destination other than 0; else the ID/EX value.
REQ-015 HD_Unit.data_o SHALL assert when the instruction in EX is lw and its rt equals rs or rt of the instruction in ID. While asserted, PC and IF/ID hold and ID/EX is loaded with a bubble (all control 0), giving a 1-cycle load-use stall.
REQ-016 beq SHALL be resolved in ID by comparing register values; target = PC_ID+4 + (signext(imm)<<2). Decision: no forwarding into ID compare; programs insert required spacing.
REQ-017 j SHALL resolve in ID; target = {PC_ID+4[31:28], addr26, 2'b00}.
REQ-018 flush SHALL be 1 in any cycle where ID holds a taken beq or a j; the next edge loads the target into PC and zeros IF/ID, giving a 1-cycle penalty and no delay slot.
REQ-019 Control.Branch_o SHALL be 1 for beq in ID; Control.IsJump_o SHALL be 1 for j in ID.

Reset
REQ-020 While rst_i=0, asynchronously: PC=0 and all pipeline registers cleared to NOP (control 0). The register file and memories are not cleared by reset.
REQ-021 After rst_i rises with start_i=1, the first fetch is address 0 on the next rising edge; PC=4 after that edge.

Verification
REQ-022 Reset then start -> PC.pc_o reads 0, 4, 8, 12 on successive edges with all-NOP memory; registers stay 0.
REQ-023 Program addi r8,r0,5; addi r9,r0,3; add r10,r8,r9 (back-to-back) -> r10=8 via forwarding; sub gives 2; mul gives 15; no stall, no flush.
REQ-024 Program addi r8,r0,7; sw r8,4(r0); lw r9,4(r0); add r10,r9,r9 -> memory bytes 4..7 = 07,00,00,00; r10=14; exactly one cycle with HD_Unit.data_o=1.
REQ-025 beq r0,r0,+1 followed by addi r8,r0,1 and then addi r9,r0,2 -> r8 stays 0, r9=2, flush=1 for exactly one cycle.
REQ-026 j to word 4 from address 0 -> PC sequence 0, 4, 16, 20; the instruction at address 4 does not write back.
REQ-027 Assert rst_i=0 mid-program -> PC=0 immediately without waiting for a clock edge; register contents are retained.

Source files
------------

// File: rtl/cpu.sv
// Five-stage in-order MIPS-subset pipeline: branch/jump resolved in ID, EX operand
// forwarding, one-cycle load-use interlock. Sub-blocks share this file.

module cpu_pc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [31:0] d_i,
  output logic [31:0] pc_o
);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i)    pc_o <= 32'd0;
    else if (en_i) pc_o <= d_i;
endmodule

module cpu_imem #(parameter int WORDS = 256, localparam int IW = $clog2(WORDS)) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [IW-1:0] addr_i,
  output logic [31:0]   data_o
);
  logic [31:0] memory [0:WORDS-1];
  always_ff @(posedge clk_i)
    if (we_i) memory[waddr_i] <= wdata_i;
  assign data_o = memory[addr_i];
endmodule

module cpu_dmem #(parameter int BYTES = 32, localparam int AW = $clog2(BYTES)) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [7:0]    memory [0:BYTES-1];
  logic [AW-1:0] a1, a2, a3;
  assign a1 = addr_i + AW'(1);
  assign a2 = addr_i + AW'(2);
  assign a3 = addr_i + AW'(3);
  // Little-endian: lowest address carries bits [7:0]
  always_ff @(posedge clk_i)
    if (we_i) begin
      memory[addr_i] <= wdata_i[7:0];
      memory[a1]     <= wdata_i[15:8];
      memory[a2]     <= wdata_i[23:16];
      memory[a3]     <= wdata_i[31:24];
    end
  assign rdata_o = {memory[a3], memory[a2], memory[a1], memory[addr_i]};
endmodule

module cpu_regfile (
  input  logic        clk_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] register [0:31];
  always_ff @(posedge clk_i)
    if (we_i && wa_i != 5'd0) register[wa_i] <= wd_i;
  // Same-cycle WB write is visible to the ID read
  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : (we_i && wa_i == ra1_i) ? wd_i : register[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : (we_i && wa_i == ra2_i) ? wd_i : register[ra2_i];
endmodule

module cpu_hazard (
  input  logic       memread_ex_i,
  input  logic [4:0] rt_ex_i,
  input  logic [4:0] rs_id_i,
  input  logic [4:0] rt_id_i,
  output logic       data_o
);
  assign data_o = memread_ex_i && (rt_ex_i == rs_id_i || rt_ex_i == rt_id_i);
endmodule

// ALU codes: 0 add, 1 sub, 2 and, 3 or, 4 mul
module cpu_control (
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic       regwrite_o,
  output logic       memtoreg_o,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       alusrc_o,
  output logic       regdst_o,
  output logic [2:0] alu_o,
  output logic       Branch_o,
  output logic       IsJump_o
);
  always_comb begin
    regwrite_o = 1'b0; memtoreg_o = 1'b0; memread_o = 1'b0; memwrite_o = 1'b0;
    alusrc_o = 1'b0; regdst_o = 1'b0; alu_o = 3'd0; Branch_o = 1'b0; IsJump_o = 1'b0;
    case (op_i)
      6'b000000: begin
        regdst_o = 1'b1;
        case (funct_i)
          6'b100000: begin regwrite_o = 1'b1; alu_o = 3'd0; end
          6'b100010: begin regwrite_o = 1'b1; alu_o = 3'd1; end
          6'b100100: begin regwrite_o = 1'b1; alu_o = 3'd2; end
          6'b100101: begin regwrite_o = 1'b1; alu_o = 3'd3; end
          6'b011000: begin regwrite_o = 1'b1; alu_o = 3'd4; end
          default: ;
        endcase
      end
      6'b001000: begin regwrite_o = 1'b1; alusrc_o = 1'b1; end
      6'b100011: begin regwrite_o = 1'b1; alusrc_o = 1'b1; memread_o = 1'b1; memtoreg_o = 1'b1; end
      6'b101011: begin alusrc_o = 1'b1; memwrite_o = 1'b1; end
      6'b000100: Branch_o = 1'b1;
      6'b000010: IsJump_o = 1'b1;
      default: ;
    endcase
  end
endmodule

module cpu #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32
) (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_BYTES);

  logic [31:0] pc, pc4, pc_next, if_ir, ifid_pc, ifid_ir;
  logic        stall, flush;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic [31:0] id_imm, id_pc4, id_a, id_b, br_target, j_target;
  logic        c_regwrite, c_memtoreg, c_memread, c_memwrite, c_alusrc, c_regdst, c_branch, c_jump;
  logic [2:0]  c_alu;

  logic        idex_regwrite, idex_memtoreg, idex_memread, idex_memwrite, idex_alusrc;
  logic [2:0]  idex_alu;
  logic [31:0] idex_a, idex_b, idex_imm;
  logic [4:0]  idex_rs, idex_rt, idex_dest;
  logic [31:0] fwd_a, fwd_b, alu_b, alu_y;

  logic        exmem_regwrite, exmem_memtoreg, exmem_memwrite;
  logic [31:0] exmem_alu, exmem_sdata, mem_rdata;
  logic [4:0]  exmem_dest;

  logic        memwb_regwrite, memwb_memtoreg;
  logic [31:0] memwb_alu, memwb_mem, wb_data;
  logic [4:0]  memwb_dest;

  // IF: a load-use stall has priority over a redirect; the redirect retries next cycle
  assign pc4     = pc + 32'd4;
  assign pc_next = flush ? (c_jump ? j_target : br_target) : pc4;

  cpu_pc PC (.clk_i(clk_i), .rst_i(rst_i), .en_i(start_i && !stall), .d_i(pc_next), .pc_o(pc));

  cpu_imem #(.WORDS(IMEM_WORDS)) Instruction_Memory (
    .clk_i(clk_i), .we_i(1'b0), .waddr_i('0), .wdata_i('0),
    .addr_i(pc[IW+1:2]), .data_o(if_ir));

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      ifid_pc <= 32'd0; ifid_ir <= 32'd0;
    end else if (start_i && !stall) begin
      ifid_pc <= flush ? 32'd0 : pc;
      ifid_ir <= flush ? 32'd0 : if_ir;
    end

  // ID
  assign id_rs     = ifid_ir[25:21];
  assign id_rt     = ifid_ir[20:16];
  assign id_imm    = {{16{ifid_ir[15]}}, ifid_ir[15:0]};
  assign id_pc4    = ifid_pc + 32'd4;
  assign br_target = id_pc4 + {id_imm[29:0], 2'b00};
  assign j_target  = {id_pc4[31:28], ifid_ir[25:0], 2'b00};
  assign id_dest   = c_regdst ? ifid_ir[15:11] : id_rt;
  assign flush     = (c_branch && id_a == id_b) || c_jump;

  cpu_control Control (
    .op_i(ifid_ir[31:26]), .funct_i(ifid_ir[5:0]),
    .regwrite_o(c_regwrite), .memtoreg_o(c_memtoreg), .memread_o(c_memread),
    .memwrite_o(c_memwrite), .alusrc_o(c_alusrc), .regdst_o(c_regdst), .alu_o(c_alu),
    .Branch_o(c_branch), .IsJump_o(c_jump));

  cpu_regfile Registers (
    .clk_i(clk_i), .ra1_i(id_rs), .ra2_i(id_rt), .we_i(memwb_regwrite),
    .wa_i(memwb_dest), .wd_i(wb_data), .rd1_o(id_a), .rd2_o(id_b));

  cpu_hazard HD_Unit (
    .memread_ex_i(idex_memread), .rt_ex_i(idex_rt), .rs_id_i(id_rs), .rt_id_i(id_rt),
    .data_o(stall));

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i || !start_i || stall) begin
      idex_regwrite <= 1'b0; idex_memtoreg <= 1'b0; idex_memread <= 1'b0;
      idex_memwrite <= 1'b0; idex_alusrc <= 1'b0; idex_alu <= 3'd0;
      idex_a <= 32'd0; idex_b <= 32'd0; idex_imm <= 32'd0;
      idex_rs <= 5'd0; idex_rt <= 5'd0; idex_dest <= 5'd0;
    end else begin
      idex_regwrite <= c_regwrite; idex_memtoreg <= c_memtoreg; idex_memread <= c_memread;
      idex_memwrite <= c_memwrite; idex_alusrc <= c_alusrc; idex_alu <= c_alu;
      idex_a <= id_a; idex_b <= id_b; idex_imm <= id_imm;
      idex_rs <= id_rs; idex_rt <= id_rt; idex_dest <= id_dest;
    end

  // EX: the rt operand is forwarded before the immediate mux so sw data is covered too
  assign fwd_a = (exmem_regwrite && exmem_dest != 5'd0 && exmem_dest == idex_rs) ? exmem_alu :
                 (memwb_regwrite && memwb_dest != 5'd0 && memwb_dest == idex_rs) ? wb_data : idex_a;
  assign fwd_b = (exmem_regwrite && exmem_dest != 5'd0 && exmem_dest == idex_rt) ? exmem_alu :
                 (memwb_regwrite && memwb_dest != 5'd0 && memwb_dest == idex_rt) ? wb_data : idex_b;
  assign alu_b = idex_alusrc ? idex_imm : fwd_b;

  always_comb begin
    alu_y = fwd_a + alu_b;
    case (idex_alu)
      3'd1:    alu_y = fwd_a - alu_b;
      3'd2:    alu_y = fwd_a & alu_b;
      3'd3:    alu_y = fwd_a | alu_b;
      3'd4:    alu_y = fwd_a * alu_b;
      default: alu_y = fwd_a + alu_b;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      exmem_regwrite <= 1'b0; exmem_memtoreg <= 1'b0; exmem_memwrite <= 1'b0;
      exmem_alu <= 32'd0; exmem_sdata <= 32'd0; exmem_dest <= 5'd0;
    end else begin
      exmem_regwrite <= idex_regwrite; exmem_memtoreg <= idex_memtoreg;
      exmem_memwrite <= idex_memwrite; exmem_alu <= alu_y;
      exmem_sdata <= fwd_b; exmem_dest <= idex_dest;
    end

  // MEM
  cpu_dmem #(.BYTES(DMEM_BYTES)) Data_Memory (
    .clk_i(clk_i), .we_i(exmem_memwrite), .addr_i(exmem_alu[DW-1:0]),
    .wdata_i(exmem_sdata), .rdata_o(mem_rdata));

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      memwb_regwrite <= 1'b0; memwb_memtoreg <= 1'b0;
      memwb_alu <= 32'd0; memwb_mem <= 32'd0; memwb_dest <= 5'd0;
    end else begin
      memwb_regwrite <= exmem_regwrite; memwb_memtoreg <= exmem_memtoreg;
      memwb_alu <= exmem_alu; memwb_mem <= mem_rdata; memwb_dest <= exmem_dest;
    end

  // WB
  assign wb_data = memwb_memtoreg ? memwb_mem : memwb_alu;
endmodule

// File: tb/tb_cpu.sv
// Directed program bench for the cpu pipeline: each program is loaded into
// instruction memory under reset, run for a fixed number of cycles, then checked.

module tb_cpu;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  int checks = 0;
  int errors = 0;
  int stall_cnt, flush_cnt, branch_cnt, jump_cnt;

  localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_MUL = 6'b011000;

  cpu dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_op(input int a);
    return {6'b000010, 26'(a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk_i);
      stall_cnt  += int'(dut.HD_Unit.data_o);
      flush_cnt  += int'(dut.flush);
      branch_cnt += int'(dut.Control.Branch_o);
      jump_cnt   += int'(dut.Control.IsJump_o);
    end
  endtask

  task automatic begin_prog;
    rst_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] <= 32'd0;
  endtask

  task automatic put(input int a, input logic [31:0] w);
    dut.Instruction_Memory.memory[a] <= w;
  endtask

  task automatic go;
    stall_cnt = 0; flush_cnt = 0; branch_cnt = 0; jump_cnt = 0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic zero_regs;
    begin_prog;
    for (int i = 0; i < 31; i++) put(i, i_op(ADDI, 0, i + 1, 0));
    go;
    run(40);
  endtask

  initial begin
    // Reset state
    #1 rst_i = 1'b0;
    #1;
    check("reset_pc", dut.PC.pc_o, 32'd0);
    check("reset_flush", {31'd0, dut.flush}, 32'd0);
    check("reset_stall", {31'd0, dut.HD_Unit.data_o}, 32'd0);

    zero_regs;

    // All-NOP memory: PC walks by 4, start_i=0 holds it, nothing is written
    begin_prog;
    go;
    check("nop_pc0", dut.PC.pc_o, 32'd0);
    run(1); check("nop_pc1", dut.PC.pc_o, 32'd4);
    run(1); check("nop_pc2", dut.PC.pc_o, 32'd8);
    run(1); check("nop_pc3", dut.PC.pc_o, 32'd12);
    start_i = 1'b0;
    run(3); check("hold_pc", dut.PC.pc_o, 32'd12);
    start_i = 1'b1;
    run(1); check("resume_pc", dut.PC.pc_o, 32'd16);
    run(10);
    check("nop_r1", dut.Registers.register[1], 32'd0);
    check("nop_r8", dut.Registers.register[8], 32'd0);
    check("nop_r31", dut.Registers.register[31], 32'd0);

    // Back-to-back ALU ops through forwarding, wrap-around, r0 writes discarded
    zero_regs;
    begin_prog;
    put(0, i_op(ADDI, 0, 8, 5));
    put(1, i_op(ADDI, 0, 9, 3));
    put(2, r_op(8, 9, 10, F_ADD));
    put(3, r_op(8, 9, 11, F_SUB));
    put(4, r_op(8, 9, 12, F_MUL));
    put(5, r_op(8, 9, 13, F_AND));
    put(6, r_op(8, 9, 14, F_OR));
    put(7, i_op(ADDI, 0, 15, -1));
    put(8, r_op(15, 15, 16, F_ADD));
    put(9, r_op(8, 9, 0, F_ADD));
    put(10, r_op(0, 8, 17, F_ADD));
    put(11, r_op(0, 8, 18, F_SUB));
    go;
    run(20);
    check("alu_add", dut.Registers.register[10], 32'd8);
    check("alu_sub", dut.Registers.register[11], 32'd2);
    check("alu_mul", dut.Registers.register[12], 32'd15);
    check("alu_and", dut.Registers.register[13], 32'd1);
    check("alu_or", dut.Registers.register[14], 32'd7);
    check("addi_neg", dut.Registers.register[15], 32'hFFFF_FFFF);
    check("add_wrap", dut.Registers.register[16], 32'hFFFF_FFFE);
    check("r0_nofwd", dut.Registers.register[17], 32'd5);
    check("sub_neg", dut.Registers.register[18], 32'hFFFF_FFFB);
    check("alu_stalls", stall_cnt, 32'd0);
    check("alu_flushes", flush_cnt, 32'd0);

    // Store, load, load-use stall; an undefined opcode must not write r31
    zero_regs;
    begin_prog;
    put(0, i_op(ADDI, 0, 8, 7));
    put(1, i_op(SW, 0, 8, 4));
    put(2, i_op(LW, 0, 9, 4));
    put(3, r_op(9, 9, 10, F_ADD));
    put(4, 32'hFFFF_FFFF);
    go;
    run(20);
    check("mem_b4", {24'd0, dut.Data_Memory.memory[4]}, 32'h07);
    check("mem_b5", {24'd0, dut.Data_Memory.memory[5]}, 32'h00);
    check("mem_b6", {24'd0, dut.Data_Memory.memory[6]}, 32'h00);
    check("mem_b7", {24'd0, dut.Data_Memory.memory[7]}, 32'h00);
    check("lw_r9", dut.Registers.register[9], 32'd7);
    check("loaduse_r10", dut.Registers.register[10], 32'd14);
    check("undef_r31", dut.Registers.register[31], 32'd0);
    check("lu_stalls", stall_cnt, 32'd1);

    // Taken beq skips one instruction; a later not-taken beq falls through
    zero_regs;
    begin_prog;
    put(0, i_op(BEQ, 0, 0, 1));
    put(1, i_op(ADDI, 0, 8, 1));
    put(2, i_op(ADDI, 0, 9, 2));
    put(6, i_op(BEQ, 0, 9, 1));
    put(7, i_op(ADDI, 0, 20, 4));
    go;
    run(20);
    check("beq_r8", dut.Registers.register[8], 32'd0);
    check("beq_r9", dut.Registers.register[9], 32'd2);
    check("beq_nt_r20", dut.Registers.register[20], 32'd4);
    check("beq_flushes", flush_cnt, 32'd1);
    check("beq_branches", branch_cnt, 32'd2);

    // Jump from address 0 to word 4
    zero_regs;
    begin_prog;
    put(0, j_op(4));
    put(1, i_op(ADDI, 0, 8, 1));
    put(4, i_op(ADDI, 0, 9, 9));
    go;
    check("j_pc0", dut.PC.pc_o, 32'd0);
    run(1); check("j_pc1", dut.PC.pc_o, 32'd4);
    run(1); check("j_pc2", dut.PC.pc_o, 32'd16);
    run(1); check("j_pc3", dut.PC.pc_o, 32'd20);
    run(10);
    check("j_r8", dut.Registers.register[8], 32'd0);
    check("j_r9", dut.Registers.register[9], 32'd9);
    check("j_flushes", flush_cnt, 32'd1);
    check("j_jumps", jump_cnt, 32'd1);

    // Mid-program asynchronous reset keeps register contents
    begin_prog;
    put(0, i_op(ADDI, 0, 21, 21));
    go;
    run(6);
    check("pre_rst_pc", dut.PC.pc_o, 32'd24);
    #2 rst_i = 1'b0;
    #1;
    check("async_rst_pc", dut.PC.pc_o, 32'd0);
    check("rst_keep_r21", dut.Registers.register[21], 32'd21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
